// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: decodes 'W'/'R' command frames from the RX byte stream,
// runs one single-word bus cycle, and streams the reply bytes to TX.
module uart_bus_master #(
   parameter int          TIMEOUT  = 255,
   parameter logic [7:0]  ACK_BYTE = 8'h06,
   parameter logic [7:0]  NAK_BYTE = 8'h15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        cyc,
   output logic        we,
   output logic [29:0] addr,
   output logic [3:0]  sel,
   output logic [31:0] data_out,
   input  logic [31:0] data_in,
   input  logic        ack,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        we_pend_q, we_pend_d;
   logic        resp_multi_q, resp_multi_d;
   logic [31:0] addr_sr_q, addr_sr_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic [15:0] tmo_q, tmo_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [29:0] addr_q, addr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] data_out_q, data_out_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        busy_q, busy_d;

   logic rx_fire, tx_fire;

   // rx_ready is decoded from state but forced low during reset
   assign rx_ready = !rst && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
   assign rx_fire  = rx_valid && rx_ready;
   assign tx_fire  = tx_valid_q && tx_ready;

   assign cyc      = cyc_q;
   assign we       = we_q;
   assign addr     = addr_q;
   assign sel      = sel_q;
   assign data_out = data_out_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      we_pend_d    = we_pend_q;
      resp_multi_d = resp_multi_q;
      addr_sr_d    = addr_sr_q;
      rd_data_d    = rd_data_q;
      tmo_d        = tmo_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      addr_d       = addr_q;
      sel_d        = sel_q;
      data_out_d   = data_out_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      busy_d       = busy_q;

      case (state_q)
         S_IDLE: begin
            idx_d = 2'd0;
            if (rx_fire) begin
               busy_d = 1'b1;
               if (rx_data == 8'h57 || rx_data == 8'h52) begin
                  we_pend_d = (rx_data == 8'h57);
                  state_d   = S_ADDR;
               end else begin
                  resp_multi_d = 1'b0;
                  tx_data_d    = NAK_BYTE;
                  tx_valid_d   = 1'b1;
                  state_d      = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (rx_fire) begin
               addr_sr_d = {rx_data, addr_sr_q[31:8]};
               idx_d     = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  idx_d = 2'd0;
                  if (addr_sr_d[1:0] != 2'b00) begin
                     resp_multi_d = 1'b0;
                     tx_data_d    = NAK_BYTE;
                     tx_valid_d   = 1'b1;
                     state_d      = S_RESP;
                  end else if (we_pend_q) begin
                     state_d = S_DATA;
                  end else begin
                     state_d = S_BUS;
                  end
               end
            end
         end
         S_DATA: begin
            if (rx_fire) begin
               data_out_d = {rx_data, data_out_q[31:8]};
               idx_d      = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            if (!cyc_q) begin
               cyc_d  = 1'b1;
               we_d   = we_pend_q;
               sel_d  = 4'hF;
               addr_d = addr_sr_q[31:2];
               tmo_d  = 16'd0;
            end else if (ack) begin
               // ack takes priority over a timeout expiring in the same cycle
               cyc_d      = 1'b0;
               we_d       = 1'b0;
               tmo_d      = 16'd0;
               tx_valid_d = 1'b1;
               state_d    = S_RESP;
               if (we_pend_q) begin
                  resp_multi_d = 1'b0;
                  tx_data_d    = ACK_BYTE;
               end else begin
                  resp_multi_d = 1'b1;
                  rd_data_d    = data_in;
                  tx_data_d    = data_in[7:0];
               end
            end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
               cyc_d        = 1'b0;
               we_d         = 1'b0;
               tmo_d        = 16'd0;
               resp_multi_d = 1'b0;
               tx_data_d    = NAK_BYTE;
               tx_valid_d   = 1'b1;
               state_d      = S_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_RESP: begin
            if (tx_fire) begin
               if (!resp_multi_q || idx_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  idx_d      = 2'd0;
                  state_d    = S_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
                  case (idx_q)
                     2'd0:    tx_data_d = rd_data_q[15:8];
                     2'd1:    tx_data_d = rd_data_q[23:16];
                     default: tx_data_d = rd_data_q[31:24];
                  endcase
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 2'd0;
         we_pend_q    <= 1'b0;
         resp_multi_q <= 1'b0;
         addr_sr_q    <= 32'd0;
         rd_data_q    <= 32'd0;
         tmo_q        <= 16'd0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 30'd0;
         sel_q        <= 4'd0;
         data_out_q   <= 32'd0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= 8'd0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         we_pend_q    <= we_pend_d;
         resp_multi_q <= resp_multi_d;
         addr_sr_q    <= addr_sr_d;
         rd_data_q    <= rd_data_d;
         tmo_q        <= tmo_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         sel_q        <= sel_d;
         data_out_q   <= data_out_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: frame decode, bus handshake, replies,
// timeout, mid-cycle reset and back-to-back frames.
module tb_uart_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid, rx_ready, tx_valid, tx_ready;
   logic [7:0]  rx_data, tx_data;
   logic        cyc, we, ack, busy;
   logic [29:0] addr;
   logic [3:0]  sel;
   logic [31:0] data_out, data_in;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;

   uart_bus_master #(.TIMEOUT(4), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .cyc(cyc), .we(we), .addr(addr), .sel(sel), .data_out(data_out),
      .data_in(data_in), .ack(ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // running count of cycles with cyc high, sampled mid-cycle
   always @(negedge clk) if (cyc) cyc_cnt = cyc_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL rx_accept: byte %h rx_ready=%b want 1", b, rx_ready);
      end
      @(negedge clk);
   endtask

   // fr holds the frame right-aligned, first byte most significant
   task automatic send_frame(input logic [71:0] fr, input int n);
      for (int i = 0; i < n; i++) send_byte(fr[8*(n-1-i) +: 8]);
      rx_valid = 1'b0;
   endtask

   task automatic recv_expect(input logic [7:0] exp);
      int n = 0;
      tx_ready = 1'b1;
      while (!tx_valid && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
         errors++;
         $display("FAIL tx_byte: got valid=%b data=%h want valid=1 data=%h", tx_valid, tx_data, exp);
      end
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   // called at the negedge right after the last frame byte was accepted
   task automatic bus_serve(input logic [29:0] ea, input logic ew, input logic [31:0] ed,
                            input int dly, input logic [31:0] rd);
      checks++;
      if (cyc !== 1'b0) begin
         errors++; $display("FAIL cyc_latency_early: cyc=%b want 0", cyc);
      end
      @(negedge clk);
      checks++;
      if (cyc !== 1'b1 || addr !== ea || we !== ew || sel !== 4'hF || busy !== 1'b1) begin
         errors++;
         $display("FAIL bus_req: cyc=%b addr=%h we=%b sel=%h busy=%b want 1 %h %b F 1",
                  cyc, addr, we, sel, busy, ea, ew);
      end
      if (ew) begin
         checks++;
         if (data_out !== ed) begin
            errors++; $display("FAIL bus_wdata: got %h want %h", data_out, ed);
         end
      end
      repeat (dly) @(negedge clk);
      checks++;
      if (cyc !== 1'b1 || rx_ready !== 1'b0) begin
         errors++; $display("FAIL bus_hold: cyc=%b rx_ready=%b want 1 0", cyc, rx_ready);
      end
      ack = 1'b1;
      data_in = rd;
      @(negedge clk);
      ack = 1'b0;
      data_in = 32'h0;
      checks++;
      if (cyc !== 1'b0 || we !== 1'b0 || tx_valid !== 1'b1 || rx_ready !== 1'b0) begin
         errors++;
         $display("FAIL bus_end: cyc=%b we=%b tx_valid=%b rx_ready=%b want 0 0 1 0",
                  cyc, we, tx_valid, rx_ready);
      end
   endtask

   task automatic check_idle(input string nm);
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || cyc !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy=%b tx_valid=%b cyc=%b want 0 0 0", nm, busy, tx_valid, cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b0; ack = 1'b0; data_in = 32'h0;
      #12;
      checks++;
      if ({cyc, we, addr, sel, data_out, tx_valid, tx_data, busy, rx_ready} !== '0) begin
         errors++;
         $display("FAIL reset_state: cyc=%b we=%b addr=%h sel=%h dout=%h txv=%b txd=%h busy=%b rxr=%b want all 0",
                  cyc, we, addr, sel, data_out, tx_valid, tx_data, busy, rx_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rx_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release: rx_ready=%b want 1", rx_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_write();
      send_frame(72'h57_00_08_00_00_EF_BE_AD_DE, 9);
      bus_serve(30'h200, 1'b1, 32'hDEADBEEF, 2, 32'h0);
      recv_expect(8'h06);
      check_idle("write");
   endtask

   task automatic test_read();
      send_frame(72'h52_04_08_00_00, 5);
      bus_serve(30'h201, 1'b0, 32'h0, 1, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h78) begin
            errors++; $display("FAIL read_hold: cycle %0d valid=%b data=%h want 1 78", i, tx_valid, tx_data);
         end
         @(negedge clk);
      end
      recv_expect(8'h78);
      recv_expect(8'h56);
      recv_expect(8'h34);
      recv_expect(8'h12);
      check_idle("read");
   endtask

   task automatic test_bad_cmd();
      int c0 = cyc_cnt;
      send_frame(72'h41, 1);
      recv_expect(8'h15);
      check_idle("badcmd");
      send_frame(72'h52_02_08_00_00, 5);
      recv_expect(8'h15);
      check_idle("misalign");
      checks++;
      if (cyc_cnt != c0) begin
         errors++; $display("FAIL nak_no_bus: cyc cycles=%0d want 0", cyc_cnt - c0);
      end
   endtask

   task automatic test_timeout();
      int c0 = cyc_cnt;
      int n = 0;
      send_frame(72'h52_10_00_00_00, 5);
      while (!tx_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (cyc_cnt - c0 != 4 || cyc !== 1'b0) begin
         errors++; $display("FAIL timeout_len: cyc cycles=%0d cyc=%b want 4 0", cyc_cnt - c0, cyc);
      end
      recv_expect(8'h15);
      check_idle("timeout");
      // ack lands in the cycle the timeout would expire
      c0 = cyc_cnt;
      send_frame(72'h52_10_00_00_00, 5);
      @(negedge clk);
      repeat (3) @(negedge clk);
      ack = 1'b1;
      data_in = 32'hCAFEF00D;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (cyc_cnt - c0 != 4 || cyc !== 1'b0 || tx_data !== 8'h0D) begin
         errors++;
         $display("FAIL timeout_ack_race: cycles=%0d cyc=%b txd=%h want 4 0 0d", cyc_cnt - c0, cyc, tx_data);
      end
      recv_expect(8'h0D);
      recv_expect(8'hF0);
      recv_expect(8'hFE);
      recv_expect(8'hCA);
      check_idle("timeout_ack");
   endtask

   task automatic test_reset_mid();
      send_frame(72'h52_00_08_00_00, 5);
      @(negedge clk);
      checks++;
      if (cyc !== 1'b1) begin
         errors++; $display("FAIL midrst_pre: cyc=%b want 1", cyc);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({cyc, busy, tx_valid, rx_ready} !== 4'b0) begin
         errors++;
         $display("FAIL midrst_async: cyc=%b busy=%b txv=%b rxr=%b want 0 0 0 0", cyc, busy, tx_valid, rx_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("midrst_after");
      send_frame(72'h52_00_08_00_00, 5);
      bus_serve(30'h200, 1'b0, 32'h0, 0, 32'hA1B2C3D4);
      recv_expect(8'hD4);
      recv_expect(8'hC3);
      recv_expect(8'hB2);
      recv_expect(8'hA1);
      check_idle("midrst_frame");
   endtask

   task automatic test_back_to_back();
      logic [71:0] f1;
      f1 = 72'h57_20_00_00_00_44_33_22_11;
      for (int i = 0; i < 9; i++) send_byte(f1[8*(8-i) +: 8]);
      rx_data = 8'h52;
      bus_serve(30'h8, 1'b1, 32'h11223344, 0, 32'h0);
      recv_expect(8'h06);
      checks++;
      if (rx_ready !== 1'b1 || rx_valid !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: rx_ready=%b rx_valid=%b busy=%b want 1 1 0", rx_ready, rx_valid, busy);
      end
      send_frame(72'h52_10_00_00_00, 5);
      bus_serve(30'h4, 1'b0, 32'h0, 1, 32'h55667788);
      recv_expect(8'h88);
      recv_expect(8'h77);
      recv_expect(8'h66);
      recv_expect(8'h55);
      check_idle("b2b");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_cmd();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
